// File: rtl/synthesijer_fmul.sv
// Pipelined floating-point multiplier: flush-to-zero, round-to-nearest-even; nd at edge k -> valid after edge k+4.
// Define FMUL_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} flags port.
module synthesijer_fmul #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic                     nd,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     valid
`ifdef FMUL_FLAGS_EN
  ,
  output logic [3:0]               flags
`endif
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned SUM_W  = SIG_W + 1;
  localparam int unsigned PROD_W = 2 * MAN_W + 2;
  localparam int unsigned E_W    = EXP_W + 2;
  localparam int unsigned BIAS   = 2 ** (EXP_W - 1) - 1;
  localparam int unsigned EMAX   = 2 ** EXP_W - 1;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN_C   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand class resolved once; the pack stage only selects on it.
  typedef enum logic [2:0] {
    K_NORM    = 3'd0,
    K_ZERO    = 3'd1,
    K_INF     = 3'd2,
    K_QNAN    = 3'd3,
    K_INVALID = 3'd4
  } kind_e;

  logic               s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q, valid_q;
  logic               s1_sign_d, s1_sign_q, s2_sign_q, s3_sign_q, s4_sign_q;
  kind_e              s1_kind_d, s1_kind_q, s2_kind_q, s3_kind_q, s4_kind_q;
  logic [EXP_W-1:0]   s1_ea_d, s1_eb_d, s1_ea_q, s1_eb_q;
  logic [MAN_W-1:0]   s1_fa_d, s1_fb_d, s1_fa_q, s1_fb_q;
  logic [PROD_W-1:0]  s2_prod_d, s2_prod_q;
  logic [E_W-1:0]     s2_exp_d, s2_exp_q, s3_exp_d, s3_exp_q, s4_exp_d, s4_exp_q;
  logic [PROD_W-1:0]  norm;
  logic [SIG_W-1:0]   s3_sig_d, s3_sig_q;
  logic               s3_guard_d, s3_guard_q, s3_sticky_d, s3_sticky_q;
  logic [SUM_W-1:0]   rnd_sum;
  logic               rnd_up, rnd_carry;
  logic [MAN_W-1:0]   s4_frac_d, s4_frac_q;
  logic               ovf, unf;
  logic [W-1:0]       result_d, result_q;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  // S1: unpack and classify
  always_comb begin
    s1_ea_d   = a[MAN_W +: EXP_W];
    s1_eb_d   = b[MAN_W +: EXP_W];
    s1_fa_d   = a[MAN_W-1:0];
    s1_fb_d   = b[MAN_W-1:0];
    s1_sign_d = a[W-1] ^ b[W-1];
    a_zero    = (s1_ea_d == '0);
    b_zero    = (s1_eb_d == '0);
    a_inf     = (&s1_ea_d) && (s1_fa_d == '0);
    b_inf     = (&s1_eb_d) && (s1_fb_d == '0);
    a_nan     = (&s1_ea_d) && (s1_fa_d != '0);
    b_nan     = (&s1_eb_d) && (s1_fb_d != '0);
    s1_kind_d = K_NORM;
    if (a_nan || b_nan)                           s1_kind_d = K_QNAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) s1_kind_d = K_INVALID;
    else if (a_inf || b_inf)                      s1_kind_d = K_INF;
    else if (a_zero || b_zero)                    s1_kind_d = K_ZERO;
  end

  // S2: significand multiply and biased exponent sum
  always_comb begin
    s2_prod_d = PROD_W'({1'b1, s1_fa_q}) * PROD_W'({1'b1, s1_fb_q});
    s2_exp_d  = {2'b00, s1_ea_q} + {2'b00, s1_eb_q} - E_W'(BIAS);
  end

  // S3: normalise so the leading one sits at the top; split off guard and sticky
  always_comb begin
    norm        = s2_prod_q[PROD_W-1] ? s2_prod_q : (s2_prod_q << 1);
    s3_sig_d    = norm[PROD_W-1 -: SIG_W];
    s3_guard_d  = norm[PROD_W-1-SIG_W];
    s3_sticky_d = |norm[PROD_W-2-SIG_W:0];
    s3_exp_d    = s2_exp_q + E_W'(s2_prod_q[PROD_W-1]);
  end

  // S3 round: nearest-even, a carry out renormalises to 1.000...
  always_comb begin
    rnd_up    = s3_guard_q & (s3_sticky_q | s3_sig_q[0]);
    rnd_sum   = {1'b0, s3_sig_q} + SUM_W'(rnd_up);
    rnd_carry = rnd_sum[SIG_W];
    s4_frac_d = rnd_carry ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];
    s4_exp_d  = s3_exp_q + E_W'(rnd_carry);
  end

  // S4: range check, special-case select and pack
  always_comb begin
    ovf      = !s4_exp_q[E_W-1] && (s4_exp_q >= E_W'(EMAX));
    unf      = s4_exp_q[E_W-1] || (s4_exp_q == '0);
    result_d = '0;
    case (s4_kind_q)
      K_QNAN, K_INVALID: result_d = QNAN_C;
      K_INF:             result_d = {s4_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      K_ZERO:            result_d = {s4_sign_q, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (ovf)      result_d = {s4_sign_q, EXP_ONES, {MAN_W{1'b0}}};
        else if (unf) result_d = {s4_sign_q, {(EXP_W+MAN_W){1'b0}}};
        else          result_d = {s4_sign_q, s4_exp_q[EXP_W-1:0], s4_frac_q};
      end
    endcase
  end

  // Tokens always advance; data registers load only behind a live token
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      s4_vld_q    <= 1'b0;
      valid_q     <= 1'b0;
      s1_sign_q   <= 1'b0;
      s2_sign_q   <= 1'b0;
      s3_sign_q   <= 1'b0;
      s4_sign_q   <= 1'b0;
      s1_kind_q   <= K_NORM;
      s2_kind_q   <= K_NORM;
      s3_kind_q   <= K_NORM;
      s4_kind_q   <= K_NORM;
      s1_ea_q     <= '0;
      s1_eb_q     <= '0;
      s1_fa_q     <= '0;
      s1_fb_q     <= '0;
      s2_prod_q   <= '0;
      s2_exp_q    <= '0;
      s3_exp_q    <= '0;
      s3_sig_q    <= '0;
      s3_guard_q  <= 1'b0;
      s3_sticky_q <= 1'b0;
      s4_exp_q    <= '0;
      s4_frac_q   <= '0;
      result_q    <= '0;
    end else begin
      s1_vld_q <= nd;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      s4_vld_q <= s3_vld_q;
      valid_q  <= s4_vld_q;
      if (nd) begin
        s1_sign_q <= s1_sign_d;
        s1_kind_q <= s1_kind_d;
        s1_ea_q   <= s1_ea_d;
        s1_eb_q   <= s1_eb_d;
        s1_fa_q   <= s1_fa_d;
        s1_fb_q   <= s1_fb_d;
      end
      if (s1_vld_q) begin
        s2_sign_q <= s1_sign_q;
        s2_kind_q <= s1_kind_q;
        s2_prod_q <= s2_prod_d;
        s2_exp_q  <= s2_exp_d;
      end
      if (s2_vld_q) begin
        s3_sign_q   <= s2_sign_q;
        s3_kind_q   <= s2_kind_q;
        s3_sig_q    <= s3_sig_d;
        s3_guard_q  <= s3_guard_d;
        s3_sticky_q <= s3_sticky_d;
        s3_exp_q    <= s3_exp_d;
      end
      if (s3_vld_q) begin
        s4_sign_q <= s3_sign_q;
        s4_kind_q <= s3_kind_q;
        s4_frac_q <= s4_frac_d;
        s4_exp_q  <= s4_exp_d;
      end
      if (s4_vld_q) begin
        result_q <= result_d;
      end
    end
  end

  assign result = result_q;
  assign valid  = valid_q;

`ifdef FMUL_FLAGS_EN
  logic       s4_inexact_d, s4_inexact_q, norm_k;
  logic [3:0] flags_d, flags_q;

  always_comb begin
    s4_inexact_d = s3_guard_q | s3_sticky_q;
    norm_k       = (s4_kind_q == K_NORM);
    flags_d      = {s4_kind_q == K_INVALID, norm_k & ovf, norm_k & unf,
                    norm_k & (ovf | unf | s4_inexact_q)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s4_inexact_q <= 1'b0;
      flags_q      <= '0;
    end else begin
      if (s3_vld_q) s4_inexact_q <= s4_inexact_d;
      if (s4_vld_q) flags_q      <= flags_d;
    end
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_synthesijer_fmul.sv
// Directed-vector bench for synthesijer_fmul: binary32 default build plus a binary16 instance.
module tb_synthesijer_fmul;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b, result;
  logic        nd, valid;
  logic [15:0] a16, b16, result16;
  logic        nd16, valid16;
`ifdef FMUL_FLAGS_EN
  logic [3:0]  flags, flags16;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] b2b_a [3] = '{32'hC0000000, 32'h3F800001, 32'h3F800800};
  logic [31:0] b2b_b [3] = '{32'h40400000, 32'h3F800001, 32'h3F800800};
  logic [31:0] b2b_r [3] = '{32'hC0C00000, 32'h3F800002, 32'h3F801000};
  logic [3:0]  b2b_f [3] = '{4'b0000, 4'b0001, 4'b0001};

  always #5 clk = ~clk;

  synthesijer_fmul dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .nd(nd), .result(result), .valid(valid)
`ifdef FMUL_FLAGS_EN
    , .flags(flags)
`endif
  );

  synthesijer_fmul #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .reset(reset), .a(a16), .b(b16), .nd(nd16), .result(result16), .valid(valid16)
`ifdef FMUL_FLAGS_EN
    , .flags(flags16)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] obs_valid(input bit is16);
    return is16 ? 64'(valid16) : 64'(valid);
  endfunction

  function automatic logic [63:0] obs_result(input bit is16);
    return is16 ? 64'(result16) : 64'(result);
  endfunction

  task automatic issue(input bit is16, input logic [31:0] x, input logic [31:0] y);
    if (is16) begin
      a16 = x[15:0]; b16 = y[15:0]; nd16 = 1'b1;
    end else begin
      a = x; b = y; nd = 1'b1;
    end
    tick();
    nd = 1'b0; nd16 = 1'b0;
    a = 'x; b = 'x; a16 = 'x; b16 = 'x;
  endtask

  task automatic check_out(input string tag, input bit is16, input logic [31:0] res,
                           input logic [3:0] flg);
    check({tag, ".valid"}, obs_valid(is16), 64'(1));
    check({tag, ".result"}, obs_result(is16), 64'(res));
`ifdef FMUL_FLAGS_EN
    check({tag, ".flags"}, is16 ? 64'(flags16) : 64'(flags), 64'(flg));
`endif
  endtask

  task automatic run_one(input string tag, input bit is16, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] res, input logic [3:0] flg);
    issue(is16, x, y);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, ".early"}, obs_valid(is16), 64'(0));
    end
    tick();
    check_out(tag, is16, res, flg);
    tick();
    check({tag, ".pulse"}, obs_valid(is16), 64'(0));
    check({tag, ".hold"}, obs_result(is16), 64'(res));
  endtask

  initial begin
    reset = 1'b1;
    nd = 1'b1;  a = 32'h3FC00000; b = 32'h40000000;
    nd16 = 1'b1; a16 = 16'h3E00;  b16 = 16'h3E00;
    repeat (3) tick();
    check("rst.valid", 64'(valid), 64'(0));
    check("rst.result", 64'(result), 64'(0));
    check("rst.valid16", 64'(valid16), 64'(0));
    check("rst.result16", 64'(result16), 64'(0));
`ifdef FMUL_FLAGS_EN
    check("rst.flags", 64'(flags), 64'(0));
`endif
    reset = 1'b0; nd = 1'b0; nd16 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst.nd_ignored", 64'(valid), 64'(0));
      check("rst.nd_ignored16", 64'(valid16), 64'(0));
    end

    run_one("mul_1p5x2", 1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);

    // Three back-to-back operations come out on three consecutive cycles
    for (int i = 0; i < 3; i++) issue(1'b0, b2b_a[i], b2b_b[i]);
    tick();
    check("b2b.early", 64'(valid), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("b2b%0d", i), 1'b0, b2b_r[i], b2b_f[i]);
    end
    tick();
    check("b2b.pulse", 64'(valid), 64'(0));
    check("b2b.hold", 64'(result), 64'(b2b_r[2]));

    run_one("inf_x_zero", 1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_one("nan_x_one",  1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);
    run_one("ninf_x_2",   1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    run_one("nzero_x_1",  1'b0, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
    run_one("overflow",   1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    run_one("underflow",  1'b0, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    run_one("rnd_carry",  1'b0, 32'h3FFFF800, 32'h3F800400, 32'h40000000, 4'b0001);

    // Reset while an operation is in flight
    issue(1'b0, 32'h3FC00000, 32'h40000000);
    tick();
    reset = 1'b1;
    #1;
    check("mid.result_cleared", 64'(result), 64'(0));
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid.no_valid", 64'(valid), 64'(0));
    end
    run_one("mid.after", 1'b0, 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);

    run_one("h.1p5sq",   1'b1, 32'h3E00, 32'h3E00, 32'h4080, 4'b0000);
    run_one("h.ovf",     1'b1, 32'h7800, 32'h7800, 32'h7C00, 4'b0101);
    run_one("h.invalid", 1'b1, 32'h7C00, 32'h0000, 32'h7E00, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/synthesijer_fmul.md
# synthesijer_fmul

Parametrised, fully pipelined IEEE-754-style floating-point multiplier for the synthesijer floating-point library. It replaces the vendor-IP binding used for 32-bit multiply with native RTL, so one module covers binary16, binary32 and binary64 (and custom formats) through generics. It keeps the library's `nd`/`valid` operator contract, so the HLS scheduler drives it with a fixed latency and no back-pressure.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored mantissa (fraction) width (≥2)
- Derived: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1
- clk  in  1  clock; all registers update on the rising edge
- reset  in  1  asynchronous, active-high reset
- a  in  W  operand A {sign, exponent, fraction}
- b  in  W  operand B
- nd  in  1  new data; a/b are sampled on every rising edge where nd=1
- result  out  W  product, registered
- valid  out  1  one-cycle strobe; result holds the product of one nd
- flags  out  4  {invalid, overflow, underflow, inexact}; present only with FMUL_FLAGS_EN

## Operation
- Four register stages: S1 unpack and classify; S2 significand multiply; S3 normalise and round; S4 special-case select and pack.
- A 1-bit valid token travels alongside the data. There is no stall and no ready: one operation is accepted per cycle, indefinitely.
- Classification: exponent 0 is treated as zero (denormal inputs are flushed; the sign is kept). Exponent all-ones with fraction 0 is inf. Exponent all-ones with fraction ≠0 is NaN.
- Sign = sign(a) XOR sign(b) for every non-NaN result.
- Significands: {1, fraction}, each MAN_W+1 bits. Product is 2·MAN_W+2 bits.
- Exponent: e = ea + eb − BIAS, computed signed, EXP_W+2 bits wide.
- Normalisation: if the product MSB is 1, shift right one and increment e.
- Rounding is round-to-nearest-even. Guard = first bit below the LSB; sticky = OR of all lower bits.
- If rounding carries out of the significand, renormalise and increment e.
- After rounding:
  - e ≥ 2^EXP_W−1 → signed inf; overflow=1, inexact=1.
  - e ≤ 0 → signed zero (flush); underflow=1, inexact=1.
- Special cases take priority, in this order:
  1. NaN in either operand, or inf×zero → canonical qNaN (sign 0, exponent all-ones, fraction MSB 1, rest 0). invalid=1 for inf×zero only.
  2. inf × nonzero → signed inf, no flags.
  3. zero × finite → signed zero, no flags.
- inexact=1 whenever guard|sticky is set on a normal result.

## Timing
- Latency is exactly 4 cycles. nd=1 sampled at edge k → valid=1 and result updated after edge k+4, for exactly one cycle.
- Back-to-back nd produces back-to-back valid, in order, with no gaps and no reordering.
- result (and flags) hold their last value while valid=0.
- Reset values: valid=0, result=0, flags=0, all pipeline tokens 0. Data registers are also cleared.
- Reset mid-operation: in-flight operations are discarded. No valid pulse occurs after reset release unless nd is asserted after release.
- nd asserted during reset is ignored.
- Operands are X-tolerant while nd=0: no token is generated.

## Configuration
- FMUL_FLAGS_EN defined: the `flags` port exists. It is registered with result and updates only when valid=1.
- Undefined: the `flags` port and its logic are absent. result and valid behave identically in both builds.

## Test plan
- Default parameters, a=0x3FC00000 (1.5), b=0x40000000 (2.0), one nd → result=0x40400000 exactly 4 cycles later, valid pulse 1 cycle, flags=0.
- Three consecutive nd pulses: (0xC0000000×0x40400000), (0x3F800001×0x3F800001), (0x3F800800×0x3F800800).
  - Three consecutive valid pulses: 0xC0C00000; 0x3F800002 with inexact; 0x3F801000 (tie rounds to even) with inexact.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, invalid.
  - 0x7FC00001×0x3F800000 → 0x7FC00000, no invalid.
  - 0xFF800000×0x40000000 → 0xFF800000.
- Range:
  - 0x7F000000×0x7F000000 → 0x7F800000, overflow+inexact.
  - 0x00800000×0x3F000000 → 0x00000000, underflow+inexact.
- Reset mid-flight: nd at cycle 0, reset pulse at cycle 2 → valid never asserts. A new nd after release yields a correct result 4 cycles later.
- EXP_W=5, MAN_W=10: 0x3E00×0x3E00 (1.5×1.5) → 0x4080 (2.25) after 4 cycles.
